// File: rtl/sdi_lock_ctrl.sv
// sdi_lock_ctrl
// Lock sequencer for the SDI-to-MIPI pixel path. Steps the pixel-clock
// divider through its phase settings, clears the misalignment detector
// before each trial, qualifies a trial phase over a number of clean frames
// and then supervises the lock.
//
// Ports:
//   sys_clk        in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   enable_i       in   sequencer run enable
//   fv_i           in   frame valid from timing generator
//   align_err_i    in   detector misalignment flag (1 = error)
//   phase_o        out  divider phase select, 0..PHASES-1
//   detector_clr_o out  detector clear, active-high
//   locked_o       out  lock achieved and held
//   lock_lost_o    out  one-cycle pulse when lock drops
//   fail_o         out  retry budget exhausted
//   retry_cnt_o    out  completed full phase sweeps since last lock/start
//   state_dbg_o    out  current FSM state (debug visibility)
//
// Handshake note: there is no valid/ready pair here; every input is a level
// sampled on each rising edge, and every output is registered and reflects
// the state entered at that edge.
module sdi_lock_ctrl #(
  parameter int PHASES        = 4,
  parameter int VERIFY_FRAMES = 2,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_RETRIES   = 8
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       fv_i,
  input  logic       align_err_i,
  output logic [1:0] phase_o,
  output logic       detector_clr_o,
  output logic       locked_o,
  output logic       lock_lost_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_dbg_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SETTLE = 3'd2,
    S_VERIFY = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  localparam logic [1:0] PHASE_LAST  = 2'(PHASES - 1);
  localparam logic [3:0] FRAMES_REQ  = 4'(VERIFY_FRAMES);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX   = 4'(MAX_RETRIES);

  state_t     state_q, state_d;
  logic       fv_q;
  logic [7:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [3:0] retry_cnt_q, retry_cnt_d;
  logic [1:0] phase_q, phase_d;
  logic       clr_q, clr_d;
  logic       locked_q, locked_d;
  logic       lost_q, lost_d;
  logic       fail_q, fail_d;
  logic       fv_rise;
  logic [3:0] retry_inc;

  assign fv_rise   = fv_i & ~fv_q;
  assign retry_inc = retry_cnt_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    phase_d      = phase_q;
    lost_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        settle_cnt_d = 8'd0;
        frame_cnt_d  = 4'd0;
        retry_cnt_d  = 4'd0;
        phase_d      = 2'd0;
        if (enable_i) state_d = S_CLEAR;
      end
      // The settle counter doubles as the 2-cycle clear timer.
      S_CLEAR: begin
        if (settle_cnt_q == 8'd1) begin
          state_d      = S_SETTLE;
          settle_cnt_d = 8'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d     = S_VERIFY;
          frame_cnt_d = 4'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      S_VERIFY: begin
        // Error wins over a completing frame count, including the
        // cycle of the final fv rise.
        if (align_err_i) begin
          settle_cnt_d = 8'd0;
          if (phase_q != PHASE_LAST) begin
            phase_d = phase_q + 2'd1;
            state_d = S_CLEAR;
          end else if (retry_inc == RETRY_MAX) begin
            // Budget spent: phase stays on the last setting tried.
            retry_cnt_d = retry_inc;
            state_d     = S_FAIL;
          end else begin
            phase_d     = 2'd0;
            retry_cnt_d = retry_inc;
            state_d     = S_CLEAR;
          end
        end else if (frame_cnt_q == FRAMES_REQ) begin
          state_d     = S_LOCKED;
          retry_cnt_d = 4'd0;
        end else if (fv_rise) begin
          frame_cnt_d = frame_cnt_q + 4'd1;
        end
      end
      S_LOCKED: begin
        // Phase is kept so the same setting is re-qualified first.
        if (align_err_i) begin
          lost_d       = 1'b1;
          settle_cnt_d = 8'd0;
          state_d      = S_CLEAR;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!enable_i) begin
      state_d      = S_IDLE;
      phase_d      = 2'd0;
      retry_cnt_d  = 4'd0;
      settle_cnt_d = 8'd0;
      frame_cnt_d  = 4'd0;
      lost_d       = 1'b0;
    end

    // Status flops are decoded from the next state so they line up with it.
    clr_d    = (state_d == S_CLEAR);
    locked_d = (state_d == S_LOCKED);
    fail_d   = (state_d == S_FAIL);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fv_q         <= 1'b0;
      settle_cnt_q <= 8'd0;
      frame_cnt_q  <= 4'd0;
      retry_cnt_q  <= 4'd0;
      phase_q      <= 2'd0;
      clr_q        <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fv_q         <= fv_i;
      settle_cnt_q <= settle_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      phase_q      <= phase_d;
      clr_q        <= clr_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
      fail_q       <= fail_d;
    end
  end

  assign phase_o        = phase_q;
  assign detector_clr_o = clr_q;
  assign locked_o       = locked_q;
  assign lock_lost_o    = lost_q;
  assign fail_o         = fail_q;
  assign retry_cnt_o    = retry_cnt_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_sdi_lock_ctrl.sv
// Testbench for sdi_lock_ctrl: directed scenarios plus randomized stimulus,
// every cycle compared against a trial-level reference model.
module tb_sdi_lock_ctrl;
  localparam int P  = 4;
  localparam int VF = 2;
  localparam int SC = 16;
  localparam int MR = 2;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable_i = 1'b0;
  logic       fv_i = 1'b0;
  logic       align_err_i = 1'b0;
  logic [1:0] phase_o;
  logic       detector_clr_o;
  logic       locked_o;
  logic       lock_lost_o;
  logic       fail_o;
  logic [3:0] retry_cnt_o;
  logic [2:0] state_dbg_o;

  always #5 sys_clk = ~sys_clk;

  sdi_lock_ctrl #(
    .PHASES(P), .VERIFY_FRAMES(VF), .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .enable_i(enable_i), .fv_i(fv_i),
    .align_err_i(align_err_i), .phase_o(phase_o),
    .detector_clr_o(detector_clr_o), .locked_o(locked_o),
    .lock_lost_o(lock_lost_o), .fail_o(fail_o), .retry_cnt_o(retry_cnt_o),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Modes of a lock attempt: off, preparing a trial (clear window followed
  // by settle window, one countdown), trialling, holding lock, given up.
  localparam int M_OFF = 0, M_PREP = 1, M_TRIAL = 2, M_HOLD = 3, M_GIVEUP = 4;
  int m_mode, m_timer, m_frames, m_phase, m_retries;
  bit m_lost, m_fv_prev;

  function automatic void model_reset();
    m_mode = M_OFF; m_timer = 0; m_frames = 0; m_phase = 0; m_retries = 0;
    m_lost = 0; m_fv_prev = 0;
  endfunction

  function automatic void start_prep();
    m_mode  = M_PREP;
    m_timer = 2 + SC;
  endfunction

  function automatic void next_phase();
    if (m_phase < P - 1) begin
      m_phase++;
      start_prep();
    end else if (m_retries + 1 == MR) begin
      m_retries++;
      m_mode = M_GIVEUP;
    end else begin
      m_phase = 0;
      m_retries++;
      start_prep();
    end
  endfunction

  function automatic void model_step();
    bit rise;
    rise      = fv_i && !m_fv_prev;
    m_fv_prev = fv_i;
    m_lost    = 0;
    if (!enable_i) begin
      m_mode = M_OFF; m_phase = 0; m_retries = 0;
      return;
    end
    case (m_mode)
      M_OFF: start_prep();
      M_PREP: begin
        m_timer--;
        if (m_timer == 0) begin m_mode = M_TRIAL; m_frames = 0; end
      end
      M_TRIAL: begin
        if (align_err_i) next_phase();
        else if (m_frames == VF) begin m_mode = M_HOLD; m_retries = 0; end
        else if (rise) m_frames++;
      end
      M_HOLD: if (align_err_i) begin m_lost = 1; start_prep(); end
      default: ;
    endcase
  endfunction

  always @(posedge sys_clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  task automatic compare_all();
    check_eq("phase_o", phase_o, m_phase);
    check_eq("detector_clr_o", detector_clr_o, (m_mode == M_PREP && m_timer > SC));
    check_eq("locked_o", locked_o, (m_mode == M_HOLD));
    check_eq("lock_lost_o", lock_lost_o, m_lost);
    check_eq("fail_o", fail_o, (m_mode == M_GIVEUP));
    check_eq("retry_cnt_o", retry_cnt_o, m_retries);
  endtask

  // ---------------- driver ----------------
  int fv_ctr = 0;
  function automatic logic fv_gen();
    fv_ctr++;
    return (fv_ctr % 8) < 4;
  endfunction

  task automatic tick(input logic en, input logic fv, input logic err);
    enable_i = en; fv_i = fv; align_err_i = err;
    @(posedge sys_clk);
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_phase"}, phase_o, 0);
    check_eq({tag, "_clr"}, detector_clr_o, 0);
    check_eq({tag, "_locked"}, locked_o, 0);
    check_eq({tag, "_lost"}, lock_lost_o, 0);
    check_eq({tag, "_fail"}, fail_o, 0);
    check_eq({tag, "_retry"}, retry_cnt_o, 0);
  endtask

  initial begin
    logic f, e;
    bit injected;
    model_reset();
    #1;
    check_all_zero("reset");
    #16 rst = 1'b0;

    // Clean run at defaults: lock on phase 0.
    tick(1, fv_gen(), 0);
    check_eq("s1_clr_first", detector_clr_o, 1);
    repeat (60) tick(1, fv_gen(), 0);
    check_eq("s1_locked", locked_o, 1);
    check_eq("s1_phase", phase_o, 0);
    repeat (2) tick(0, fv_gen(), 0);

    // Errors on phases 0 and 1, clean on phase 2.
    repeat (200) tick(1, fv_gen(), (m_mode == M_TRIAL && m_phase < 2));
    check_eq("s2_locked", locked_o, 1);
    check_eq("s2_phase", phase_o, 2);
    repeat (2) tick(0, fv_gen(), 0);

    // Error held high: 8 trials then fail at phase 3.
    repeat (300) tick(1, fv_gen(), 1);
    check_eq("s3_fail", fail_o, 1);
    check_eq("s3_phase", phase_o, 3);
    check_eq("s3_retry", retry_cnt_o, MR);
    tick(0, fv_gen(), 1);
    check_all_zero("s3_off");

    // Lock at phase 1, single error pulse, relock at phase 1.
    repeat (120) tick(1, fv_gen(), (m_mode == M_TRIAL && m_phase == 0));
    check_eq("s4_locked", locked_o, 1);
    check_eq("s4_phase", phase_o, 1);
    tick(1, fv_gen(), 1);
    check_eq("s4_lost", lock_lost_o, 1);
    check_eq("s4_unlocked", locked_o, 0);
    tick(1, fv_gen(), 0);
    check_eq("s4_lost_pulse", lock_lost_o, 0);
    repeat (80) tick(1, fv_gen(), 0);
    check_eq("s4_relocked", locked_o, 1);
    check_eq("s4_rephase", phase_o, 1);
    repeat (2) tick(0, fv_gen(), 0);

    // Error coincident with the final fv rise.
    injected = 0;
    for (int i = 0; i < 100 && !injected; i++) begin
      f = fv_gen();
      e = (m_mode == M_TRIAL && m_frames == VF - 1 && f && !m_fv_prev);
      injected = e;
      tick(1, f, e);
      check_eq("s5_no_lock", locked_o, 0);
    end
    check_eq("s5_phase_adv", phase_o, 1);
    repeat (2) tick(0, fv_gen(), 0);

    // Async reset mid-settle.
    repeat (10) tick(1, fv_gen(), 0);
    #3 rst = 1'b1;
    #1 check_all_zero("s6_rst");
    @(posedge sys_clk);
    #3 rst = 1'b0;
    // Enable dropped mid-verify.
    for (int i = 0; i < 40 && m_mode != M_TRIAL; i++) tick(1, fv_gen(), 0);
    check_eq("s6_in_verify", state_dbg_o, 3);
    repeat (3) tick(1, fv_gen(), 0);
    tick(0, fv_gen(), 0);
    check_all_zero("s6_en_low");

    // Randomized soak.
    for (int i = 0; i < 2000; i++) begin
      f = ($urandom_range(0, 9) < 2) ? logic'($urandom_range(0, 1)) : fv_gen();
      tick($urandom_range(0, 199) != 0, f, $urandom_range(0, 99) < 3);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
